// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / instruction-fetch stage: condition codes,
// flag bit positions and the fetch state encoding.
package pc_fetch_unit_pkg;

  localparam logic [3:0] COND_EQ    = 4'h0;
  localparam logic [3:0] COND_NE    = 4'h1;
  localparam logic [3:0] COND_CS    = 4'h2;
  localparam logic [3:0] COND_CC    = 4'h3;
  localparam logic [3:0] COND_HI    = 4'h4;
  localparam logic [3:0] COND_LS    = 4'h5;
  localparam logic [3:0] COND_GT    = 4'h6;
  localparam logic [3:0] COND_LE    = 4'h7;
  localparam logic [3:0] COND_FS    = 4'h8;
  localparam logic [3:0] COND_FC    = 4'h9;
  localparam logic [3:0] COND_LO    = 4'hA;
  localparam logic [3:0] COND_HS    = 4'hB;
  localparam logic [3:0] COND_LT    = 4'hC;
  localparam logic [3:0] COND_GE    = 4'hD;
  localparam logic [3:0] COND_UC    = 4'hE;
  localparam logic [3:0] COND_NEVER = 4'hF;

  // Bit positions inside the {N,Z,F,L,C} flag vector.
  localparam int FLAG_N    = 4;
  localparam int FLAG_Z    = 3;
  localparam int FLAG_F    = 2;
  localparam int FLAG_L    = 1;
  localparam int FLAG_C    = 0;
  localparam int NUM_FLAGS = 5;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

endpackage : pc_fetch_unit_pkg

// File: rtl/pc_fetch_unit_cond_eval.sv
// Condition-code evaluator: decides whether a conditional jump/branch is
// taken from the 4-bit code and the processor flags.
module cond_eval
  import pc_fetch_unit_pkg::*;
(
  input  logic [3:0]           flagOp,
  input  logic [NUM_FLAGS-1:0] flags,
  output logic                 taken
);

  logic n_flag;
  logic z_flag;
  logic f_flag;
  logic l_flag;
  logic c_flag;

  assign n_flag = flags[FLAG_N];
  assign z_flag = flags[FLAG_Z];
  assign f_flag = flags[FLAG_F];
  assign l_flag = flags[FLAG_L];
  assign c_flag = flags[FLAG_C];

  always_comb begin
    taken = 1'b0;
    unique case (flagOp)
      COND_EQ:    taken = z_flag;
      COND_NE:    taken = !z_flag;
      COND_CS:    taken = c_flag;
      COND_CC:    taken = !c_flag;
      COND_HI:    taken = l_flag;
      COND_LS:    taken = !l_flag;
      COND_GT:    taken = n_flag;
      COND_LE:    taken = !n_flag;
      COND_FS:    taken = f_flag;
      COND_FC:    taken = !f_flag;
      // Compound codes combine magnitude/sign with equality.
      COND_LO:    taken = !l_flag && !z_flag;
      COND_HS:    taken = l_flag || z_flag;
      COND_LT:    taken = !n_flag && !z_flag;
      COND_GE:    taken = n_flag || z_flag;
      COND_UC:    taken = 1'b1;
      COND_NEVER: taken = 1'b0;
      default:    taken = 1'b0;
    endcase
  end

endmodule : cond_eval

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: owns the PC, fetches the word at the
// PC over a req/ack port and holds it on `instruction` until the PC moves.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pcAdd,
  input  logic                 pcJump,
  input  logic                 pcBranch,
  input  logic [3:0]           flagOp,
  input  logic [WIDTH-1:0]     immediate,
  input  logic [WIDTH-1:0]     jump_target,
  input  logic [NUM_FLAGS-1:0] flags,
  input  logic [15:0]          mem_rdata,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic [WIDTH-1:0]     mem_addr,
  output logic [15:0]          instruction,
  output logic                 instr_valid,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_link
);

  localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]      instruction_q, instruction_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fetch_pending_q, fetch_pending_d;

  logic             taken;
  logic             pc_update;
  logic             accept;
  logic [WIDTH-1:0] pc_plus1;

  cond_eval u_cond_eval (
    .flagOp (flagOp),
    .flags  (flags),
    .taken  (taken)
  );

  // Any strobe is a PC update, even when the condition fails and pc+1 results.
  assign pc_update = pcAdd || pcJump || pcBranch;
  assign pc_plus1  = pc_q + PC_ONE;

  always_comb begin
    pc_d = pc_q;
    if (pcJump) begin
      pc_d = taken ? jump_target : pc_plus1;
    end else if (pcBranch) begin
      pc_d = taken ? (pc_q + immediate) : pc_plus1;
    end else if (pcAdd) begin
      pc_d = pc_plus1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A request is launched only from a cycle with a stable
  // PC, so a strobe in IDLE defers the fetch by one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_IDLE: begin
        if (fetch_pending_q && !pc_update) begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (mem_ack) begin
          state_d = FETCH_IDLE;
        end else if (pc_update) begin
          state_d = FETCH_DISCARD;
        end
      end
      FETCH_DISCARD: begin
        if (mem_ack) begin
          state_d = FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // Output logic: an issued request stays up until the memory acknowledges it.
  always_comb begin
    mem_req = (state_q != FETCH_IDLE);
  end

  // Fetched data is only usable if the PC did not move in the ack cycle.
  assign accept = (state_q == FETCH_REQ) && mem_ack && !pc_update;

  always_comb begin
    fetch_pending_d = fetch_pending_q;
    instr_valid_d   = instr_valid_q;
    instruction_d   = instruction_q;
    mem_addr_d      = mem_addr_q;

    if (pc_update) begin
      fetch_pending_d = 1'b1;
      instr_valid_d   = 1'b0;
    end else if (accept) begin
      fetch_pending_d = 1'b0;
      instr_valid_d   = 1'b1;
    end

    if (accept) begin
      instruction_d = mem_rdata;
    end

    if ((state_q == FETCH_IDLE) && (state_d == FETCH_REQ)) begin
      mem_addr_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q            <= RESET_PC;
      mem_addr_q      <= RESET_PC;
      instruction_q   <= 16'h0000;
      instr_valid_q   <= 1'b0;
      fetch_pending_q <= 1'b1;
    end else begin
      pc_q            <= pc_d;
      mem_addr_q      <= mem_addr_d;
      instruction_q   <= instruction_d;
      instr_valid_q   <= instr_valid_d;
      fetch_pending_q <= fetch_pending_d;
    end
  end

  assign pc          = pc_q;
  assign pc_link     = pc_plus1;
  assign mem_addr    = mem_addr_q;
  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset fetch, next-PC selection, condition
// codes, wait states, and PC updates that race an outstanding fetch.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        pcAdd;
  logic        pcJump;
  logic        pcBranch;
  logic [3:0]  flagOp;
  logic [15:0] immediate;
  logic [15:0] jump_target;
  logic [4:0]  flags;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_link;

  int total;
  int bad;

  pc_fetch_unit #(
    .WIDTH    (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pcAdd       (pcAdd),
    .pcJump      (pcJump),
    .pcBranch    (pcBranch),
    .flagOp      (flagOp),
    .immediate   (immediate),
    .jump_target (jump_target),
    .flags       (flags),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_link     (pc_link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle controller strobe; inputs change 1 time unit after the edge.
  task automatic pulse(input logic add, input logic jmp, input logic br,
                       input logic [3:0] op, input logic [15:0] imm,
                       input logic [15:0] tgt);
    pcAdd = add; pcJump = jmp; pcBranch = br;
    flagOp = op; immediate = imm; jump_target = tgt;
    step();
    pcAdd = 1'b0; pcJump = 1'b0; pcBranch = 1'b0;
    $display("strobe add=%b jump=%b branch=%b op=%h flags=%b -> pc=%h", add, jmp, br, op, flags, pc);
  endtask

  // Zero-wait memory until the fetch lands; bounded so a stuck DUT still ends.
  task automatic settle(input string tag, input logic [15:0] exp_addr, input logic [15:0] data);
    logic [15:0] seen;
    logic        got;
    seen = 16'hxxxx;
    got  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = data;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (mem_req) seen = mem_addr;
      if (instr_valid) got = 1'b1;
    end
    mem_ack = 1'b0;
    check({tag, "_valid"}, {15'd0, got}, 16'h0001);
    check({tag, "_addr"}, seen, exp_addr);
    check({tag, "_instr"}, instruction, data);
    $display("fetch %s addr=%h instr=%h valid=%b", tag, seen, instruction, instr_valid);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    pcAdd = 1'b0; pcJump = 1'b0; pcBranch = 1'b0;
    flagOp = 4'h0; immediate = 16'h0000; jump_target = 16'h0000;
    flags = 5'b00000;
    mem_ack = 1'b1;
    mem_rdata = 16'h5301;

    // Reset state, then the first fetch of RESET_PC with ack tied high.
    #12;
    check("rst_pc", pc, 16'h0000);
    check("rst_req", {15'd0, mem_req}, 16'h0000);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_valid", {15'd0, instr_valid}, 16'h0000);
    check("rst_instr", instruction, 16'h0000);
    reset = 1'b1;
    step();
    check("boot_req", {15'd0, mem_req}, 16'h0001);
    check("boot_addr", mem_addr, 16'h0000);
    check("boot_valid0", {15'd0, instr_valid}, 16'h0000);
    step();
    check("boot_valid1", {15'd0, instr_valid}, 16'h0001);
    check("boot_instr", instruction, 16'h5301);
    check("boot_req_drop", {15'd0, mem_req}, 16'h0000);
    mem_ack = 1'b0;
    $display("boot pc=%h instr=%h", pc, instruction);

    // Add: pc 5 -> 6, link 7, refetch at 6.
    pulse(1'b0, 1'b1, 1'b0, 4'hE, 16'h0000, 16'h0005);
    check("jmp5_pc", pc, 16'h0005);
    settle("at5", 16'h0005, 16'h1111);
    pulse(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
    check("add_pc", pc, 16'h0006);
    check("add_link", pc_link, 16'h0007);
    check("add_valid_clr", {15'd0, instr_valid}, 16'h0000);
    settle("at6", 16'h0006, 16'h2222);

    // Branch EQ taken (negative displacement) and not taken.
    pulse(1'b0, 1'b1, 1'b0, 4'hE, 16'h0000, 16'h0020);
    flags = 5'b01000;
    pulse(1'b0, 1'b0, 1'b1, 4'h0, 16'hFFFC, 16'h0000);
    check("br_eq_taken", pc, 16'h001C);
    pulse(1'b0, 1'b1, 1'b0, 4'hE, 16'h0000, 16'h0020);
    flags = 5'b00000;
    pulse(1'b0, 1'b0, 1'b1, 4'h0, 16'hFFFC, 16'h0000);
    check("br_eq_not", pc, 16'h0021);

    // Compound and carry conditions: LO, LO with L set, CS.
    pulse(1'b0, 1'b0, 1'b1, 4'hA, 16'h0004, 16'h0000);
    check("br_lo_taken", pc, 16'h0025);
    flags = 5'b00010;
    pulse(1'b0, 1'b0, 1'b1, 4'hA, 16'h0004, 16'h0000);
    check("br_lo_not", pc, 16'h0026);
    flags = 5'b00001;
    pulse(1'b0, 1'b0, 1'b1, 4'h2, 16'h0010, 16'h0000);
    check("br_cs_taken", pc, 16'h0036);
    flags = 5'b00000;

    // Jumps: unconditional, never, and the wrap at the top of memory.
    pulse(1'b0, 1'b1, 1'b0, 4'hE, 16'h0000, 16'h1234);
    check("jmp_uc", pc, 16'h1234);
    pulse(1'b0, 1'b1, 1'b0, 4'hF, 16'h0000, 16'h0000);
    check("jmp_never", pc, 16'h1235);
    pulse(1'b0, 1'b1, 1'b0, 4'hE, 16'h0000, 16'hFFFF);
    check("link_wrap", pc_link, 16'h0000);
    pulse(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
    check("add_wrap", pc, 16'h0000);
    settle("at0", 16'h0000, 16'h3333);

    // Three wait cycles: request and address held, valid one edge after ack.
    pulse(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
    check("lat_req_n", {15'd0, mem_req}, 16'h0000);
    step();
    check("wait1_req", {15'd0, mem_req}, 16'h0001);
    check("wait1_addr", mem_addr, 16'h0001);
    step();
    check("wait2_req", {15'd0, mem_req}, 16'h0001);
    check("wait2_addr", mem_addr, 16'h0001);
    check("wait2_valid", {15'd0, instr_valid}, 16'h0000);
    step();
    check("wait3_req", {15'd0, mem_req}, 16'h0001);
    check("wait3_addr", mem_addr, 16'h0001);
    mem_ack = 1'b1;
    mem_rdata = 16'h4444;
    step();
    mem_ack = 1'b0;
    check("wait_valid", {15'd0, instr_valid}, 16'h0001);
    check("wait_instr", instruction, 16'h4444);
    $display("wait-state fetch instr=%h", instruction);

    // PC update while the request for 8 is outstanding: its data is dropped.
    pulse(1'b0, 1'b1, 1'b0, 4'hE, 16'h0000, 16'h0008);
    step();
    check("mid_req8", mem_addr, 16'h0008);
    pulse(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
    check("mid_pc9", pc, 16'h0009);
    check("disc_req", {15'd0, mem_req}, 16'h0001);
    check("disc_addr", mem_addr, 16'h0008);
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    check("disc_valid", {15'd0, instr_valid}, 16'h0000);
    check("disc_instr", instruction, 16'h4444);
    check("disc_req_drop", {15'd0, mem_req}, 16'h0000);
    step();
    check("refetch_req", {15'd0, mem_req}, 16'h0001);
    check("refetch_addr", mem_addr, 16'h0009);
    mem_ack = 1'b1;
    mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    check("refetch_valid", {15'd0, instr_valid}, 16'h0001);
    check("refetch_instr", instruction, 16'hBEEF);

    // Ack arriving in the same cycle as a PC update is also dropped.
    pulse(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
    step();
    check("race_addr", mem_addr, 16'h000A);
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    pulse(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
    mem_ack = 1'b0;
    check("race_pc", pc, 16'h000B);
    check("race_valid", {15'd0, instr_valid}, 16'h0000);
    check("race_instr", instruction, 16'hBEEF);
    settle("atB", 16'h000B, 16'h5555);

    // Asynchronous reset in the middle of a request.
    pulse(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
    step();
    check("pre_arst_req", {15'd0, mem_req}, 16'h0001);
    #2;
    reset = 1'b0;
    #1;
    check("arst_req", {15'd0, mem_req}, 16'h0000);
    check("arst_pc", pc, 16'h0000);
    check("arst_valid", {15'd0, instr_valid}, 16'h0000);
    #1;
    reset = 1'b1;
    settle("reboot", 16'h0000, 16'h6666);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_fetch_unit
